// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared states, defaults and requester indices for the UDP transmit arbiter
package udp_tx_pkg;
  localparam int DEF_LEN_W = 12;
  localparam logic [11:0] DEF_MIN_LEN = 12'd1;
  localparam logic [19:0] DEF_TO_CYC = 20'd125000;
  localparam int REQ_ADC = 0;
  localparam int REQ_CMD = 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4,
    REJ  = 3'd5
  } state_t;
endpackage

// File: rtl/udp_tx_arb_rr.sv
// rr_arb2: two-way round-robin grant; the pointer moves past the requester just served
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_idx,
  output logic [1:0] o_gnt
);
  logic r_ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_idx;
  assign o_gnt = r_ptr ? (i_req[1] ? 2'b10 : {1'b0, i_req[0]})
                       : (i_req[0] ? 2'b01 : {i_req[1], 1'b0});
endmodule

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin scheduler of two packet sources onto the mac UDP transmit path
module udp_tx_arb
  import udp_tx_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter logic [LEN_W-1:0] MIN_LEN = LEN_W'(DEF_MIN_LEN),
  parameter logic [19:0] TO_CYC = DEF_TO_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             rd_en0,
  output logic             rd_en1,
  input  logic [7:0]       rxd0,
  input  logic [7:0]       rxd1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic             fs_udp_tx,
  input  logic             fd_udp_tx,
  output logic [LEN_W-1:0] udp_tx_len,
  input  logic             flag_udp_tx_prep,
  input  logic             flag_udp_tx_req,
  input  logic             udp_txen,
  output logic [7:0]       udp_txd,
  output logic [1:0]       gnt,
  output logic [2:0]       so
);
  state_t r_st, w_nxt;
  logic [1:0] r_gnt, w_arb, r_fwd, w_rd;
  logic [LEN_W-1:0] r_len, r_cnt, w_len;
  logic r_fs, w_to, w_end, w_busy;
  assign w_busy = (r_st == WAIT) || (r_st == SEND);
`ifdef UDP_TX_TO_EN
  logic [19:0] r_to;
  assign w_to = w_busy && (r_to == TO_CYC);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_to <= 20'd0;
    else r_to <= (w_busy && !udp_txen && !w_to) ? r_to + 20'd1 : 20'd0;
`else
  assign w_to = 1'b0;
`endif
  assign w_end = (r_st == DONE) || (r_st == REJ) || w_to;
  rr_arb2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .i_req({req1, req0}),
    .i_adv(w_end),
    .i_idx(r_gnt[REQ_CMD]),
    .o_gnt(w_arb)
  );
  assign w_len = w_arb[REQ_CMD] ? len1 : len0;
  assign w_rd = {2{(r_st == SEND) && udp_txen && (r_cnt < r_len)}} & r_gnt;
  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      IDLE: w_nxt = (req0 | req1) ? ARB : IDLE;
      ARB:  w_nxt = (w_arb == 2'b00) ? IDLE : (w_len < MIN_LEN) ? REJ : WAIT;
      WAIT: w_nxt = fd_udp_tx ? DONE : w_to ? IDLE : flag_udp_tx_req ? SEND : WAIT;
      SEND: w_nxt = fd_udp_tx ? DONE : w_to ? IDLE : SEND;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_st  <= IDLE;
      r_gnt <= 2'b00;
      r_len <= '0;
      r_cnt <= '0;
      r_fs  <= 1'b0;
      r_fwd <= 2'b00;
    end else begin
      r_st  <= w_nxt;
      r_fwd <= w_rd;
      r_fs  <= ((w_nxt == WAIT) || (w_nxt == SEND)) && (r_fs || ((r_st == WAIT) && flag_udp_tx_prep));
      if (r_st == ARB) begin
        r_gnt <= w_arb;
        r_len <= w_len;
        r_cnt <= '0;
      end else if (w_nxt == IDLE) r_gnt <= 2'b00;
      if (|w_rd) r_cnt <= r_cnt + LEN_W'(1);
    end
  assign udp_txd    = r_fwd[REQ_ADC] ? rxd0 : r_fwd[REQ_CMD] ? rxd1 : 8'h00;
  assign rd_en0     = w_rd[REQ_ADC];
  assign rd_en1     = w_rd[REQ_CMD];
  assign done0      = w_end && r_gnt[REQ_ADC];
  assign done1      = w_end && r_gnt[REQ_CMD];
  assign err0       = ((r_st == REJ) || w_to) && r_gnt[REQ_ADC];
  assign err1       = ((r_st == REJ) || w_to) && r_gnt[REQ_CMD];
  assign fs_udp_tx  = r_fs && !w_to;
  assign udp_tx_len = r_len;
  assign gnt        = r_gnt;
  assign so         = r_st;
endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: randomized packet traffic against a transaction-level model of the arbiter
module tb_udp_tx_arb;
  localparam int LEN_W = 12;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 0, req1 = 0, fd_udp_tx = 0, flag_udp_tx_prep = 0, flag_udp_tx_req = 0, udp_txen = 0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [7:0] rxd0, rxd1;
  logic rd_en0, rd_en1, done0, done1, err0, err1, fs_udp_tx;
  logic [LEN_W-1:0] udp_tx_len;
  logic [7:0] udp_txd;
  logic [1:0] gnt;
  logic [2:0] so;
  int n_chk = 0, n_fail = 0;
  int ptr = 0, cur = -1;
  int nrd[2] = '{0, 0};
  logic payload = 0, exp_fwd = 0, pend = 0;
  logic [7:0] exp_txd = 8'h00;
  logic [7:0] fq0[$], fq1[$];

  always #4 clk = ~clk;

  udp_tx_arb #(.TO_CYC(20'd100)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .rd_en0(rd_en0), .rd_en1(rd_en1), .rxd0(rxd0), .rxd1(rxd1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
    .flag_udp_tx_prep(flag_udp_tx_prep), .flag_udp_tx_req(flag_udp_tx_req),
    .udp_txen(udp_txen), .udp_txd(udp_txd), .gnt(gnt), .so(so)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int p, input logic [1:0] m);
    return m[p] ? p : 1 - p;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      rxd0 <= 8'h00;
      rxd1 <= 8'h00;
    end else begin
      if (rd_en0 && fq0.size() > 0) rxd0 <= fq0.pop_front();
      if (rd_en1 && fq1.size() > 0) rxd1 <= fq1.pop_front();
    end

  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else begin
      if (pend) chk("udp_txd", {24'd0, udp_txd}, {24'd0, exp_txd});
      chk("rd_en0", {31'd0, rd_en0}, {31'd0, udp_txen && payload && cur == 0 && exp_fwd});
      chk("rd_en1", {31'd0, rd_en1}, {31'd0, udp_txen && payload && cur == 1 && exp_fwd});
      if (rd_en0) nrd[0]++;
      if (rd_en1) nrd[1]++;
      pend = udp_txen && payload;
      exp_txd = 8'h00;
      if (udp_txen && payload && exp_fwd)
        exp_txd = (cur == 1) ? (fq1.size() > 0 ? fq1[0] : 8'h00) : (fq0.size() > 0 ? fq0[0] : 8'h00);
    end
  end

  task automatic raise(input int r, input int l);
    for (int i = 0; i < l; i++)
      if (r == 1) fq1.push_back(8'($urandom_range(0, 255)));
      else fq0.push_back(8'($urandom_range(0, 255)));
    if (r == 1) begin len1 = LEN_W'(l); req1 = 1'b1; end
    else begin len0 = LEN_W'(l); req0 = 1'b1; end
  endtask

  task automatic strobe(input int i, input int l);
    udp_txen = 1'b1;
    exp_fwd = (i < l);
    tick;
    udp_txen = 1'b0;
    exp_fwd = 1'b0;
  endtask

  task automatic serve(input int e, input int nstr, input bit fd_wait);
    int l, r0, k;
    l = (e == 1) ? int'(len1) : int'(len0);
    r0 = nrd[e];
    cur = e;
    tick;
    chk("so_arb", {29'd0, so}, 32'd1);
    tick;
    chk("gnt", {30'd0, gnt}, 32'd1 << e);
    chk("udp_tx_len", {20'd0, udp_tx_len}, l);
    if (l == 0) begin
      chk("rej_done", {31'd0, (e == 1) ? done1 : done0}, 32'd1);
      chk("rej_err", {31'd0, (e == 1) ? err1 : err0}, 32'd1);
      chk("rej_fs", {31'd0, fs_udp_tx}, 32'd0);
      if (e == 1) req1 = 1'b0; else req0 = 1'b0;
      ptr = 1 - e;
      tick;
      chk("rej_idle_gnt", {30'd0, gnt}, 32'd0);
      cur = -1;
      return;
    end
    chk("so_wait", {29'd0, so}, 32'd2);
    chk("fs_before_prep", {31'd0, fs_udp_tx}, 32'd0);
    flag_udp_tx_prep = 1'b1;
    k = 0;
    while (!fs_udp_tx && k < 5) begin tick; k++; end
    chk("fs_up", {31'd0, fs_udp_tx}, 32'd1);
    if (!fd_wait) begin
      flag_udp_tx_req = 1'b1;
      tick;
      chk("so_send", {29'd0, so}, 32'd3);
      payload = 1'b1;
      for (int i = 0; i < nstr; i++) begin
        strobe(i, l);
        repeat ($urandom_range(0, 2)) tick;
      end
      tick;
      payload = 1'b0;
      flag_udp_tx_req = 1'b0;
      chk("rd_count", nrd[e] - r0, (nstr < l) ? nstr : l);
    end
    fd_udp_tx = 1'b1;
    tick;
    fd_udp_tx = 1'b0;
    flag_udp_tx_prep = 1'b0;
    chk("done", {31'd0, (e == 1) ? done1 : done0}, 32'd1);
    chk("done_other", {31'd0, (e == 1) ? done0 : done1}, 32'd0);
    chk("err", {30'd0, err1, err0}, 32'd0);
    chk("fs_down", {31'd0, fs_udp_tx}, 32'd0);
    if (e == 1) req1 = 1'b0; else req0 = 1'b0;
    ptr = 1 - e;
    tick;
    chk("idle_so", {29'd0, so}, 32'd0);
    chk("idle_gnt", {30'd0, gnt}, 32'd0);
    cur = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_so", {29'd0, so}, 32'd0);
    chk("rst_outs", {22'd0, fs_udp_tx, rd_en0, rd_en1, done0, done1, err0, err1, gnt, 1'b0}, 32'd0);
    chk("rst_len", {20'd0, udp_tx_len}, 32'd0);
    tick;
    rst = 1'b1;
    tick;
    for (int p = 0; p < 2; p++) begin
      raise(0, 3);
      raise(1, 5);
      chk("model_pair_first", pick(ptr, {req1, req0}), 0);
      serve(0, 3, 0);
      serve(1, 5, 0);
    end
    raise(0, 8);
    serve(0, 8, 0);
    raise(1, 0);
    chk("model_rej", pick(ptr, {req1, req0}), 1);
    serve(1, 0, 0);
    raise(0, 4);
    chk("model_over", pick(ptr, {req1, req0}), 0);
    serve(0, 6, 0);
    raise(0, 8);
    tick;
    tick;
    flag_udp_tx_prep = 1'b1;
    tick;
    flag_udp_tx_req = 1'b1;
    tick;
    cur = 0;
    payload = 1'b1;
    strobe(0, 8);
    strobe(1, 8);
    udp_txen = 1'b1;
    payload = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", {22'd0, fs_udp_tx, rd_en0, rd_en1, done0, done1, err0, err1, gnt, 1'b0}, 32'd0);
    chk("rst_mid_so", {29'd0, so}, 32'd0);
    chk("rst_mid_txd", {24'd0, udp_txd}, 32'd0);
    udp_txen = 1'b0;
    flag_udp_tx_req = 1'b0;
    flag_udp_tx_prep = 1'b0;
    req0 = 1'b0;
    fq0.delete();
    fq1.delete();
    ptr = 0;
    cur = -1;
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_so", {29'd0, so}, 32'd0);
    chk("post_rst_gnt", {30'd0, gnt}, 32'd0);
    for (int it = 0; it < 30; it++) begin
      int e, l;
      if (!req0 && !req1) begin
        logic [1:0] m;
        m = 2'($urandom_range(1, 3));
        for (int r = 0; r < 2; r++)
          if (m[r]) raise(r, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12));
      end
      e = pick(ptr, {req1, req0});
      l = (e == 1) ? int'(len1) : int'(len0);
      serve(e, $urandom_range(l, l + 3), $urandom_range(0, 5) == 0);
    end
    while (req0 || req1) serve(pick(ptr, {req1, req0}), 12, 0);
`ifdef UDP_TX_TO_EN
    begin
      int e, n;
      raise(0, 4);
      e = pick(ptr, {req1, req0});
      cur = e;
      tick;
      tick;
      flag_udp_tx_prep = 1'b1;
      tick;
      flag_udp_tx_req = 1'b1;
      tick;
      payload = 1'b1;
      strobe(0, 4);
      strobe(1, 4);
      n = 0;
      while (!done0 && n < 200) begin tick; n++; end
      chk("to_cycles", n, 100);
      chk("to_err", {31'd0, err0}, 32'd1);
      chk("to_fs", {31'd0, fs_udp_tx}, 32'd0);
      payload = 1'b0;
      flag_udp_tx_req = 1'b0;
      flag_udp_tx_prep = 1'b0;
      req0 = 1'b0;
      ptr = 1 - e;
      tick;
      chk("to_idle", {29'd0, so}, 32'd0);
      fq0.delete();
      cur = -1;
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
Name: udp_tx_arb

Overview:
- Two-requester scheduler for the shared MAC UDP transmit path.
- Requester 0 is the ADC data packer. Requester 1 is the command reply/status source.
- The block arbitrates round-robin, drives the fs/fd start handshake and udp_tx_len into mac, and routes mac's byte strobes to the granted requester's FIFO.
- Lives in the gmii_txc domain, between the packet FIFOs and mac.

Parameters:
- LEN_W, 12, width of packet length fields (bytes).
- MIN_LEN, 12'd1, smallest legal length; requests below it are rejected.
- TO_CYC, 20'd125000, timeout in clk cycles (1 ms at 125 MHz). Used only with UDP_TX_TO_EN.

Ports:
- clk  in  1  gmii_txc.
- rst  in  1  async reset, active-low.
- req0, req1  in  1  level request; held until the matching done pulse.
- len0, len1  in  LEN_W  payload length; sampled at grant.
- rd_en0, rd_en1  out  1  FIFO read strobe to requester 0/1.
- rxd0, rxd1  in  8  FIFO dout of requester 0/1; first-word-fall-through not assumed, one-cycle read latency.
- done0, done1  out  1  one-cycle pulse: packet sent or rejected.
- err0, err1  out  1  one-cycle pulse alongside done: rejected or timed out.
- fs_udp_tx  out  1  start to mac.
- fd_udp_tx  in  1  done from mac.
- udp_tx_len  out  LEN_W  registered length for mac.
- flag_udp_tx_prep  in  1  mac ready to accept a new packet.
- flag_udp_tx_req  in  1  mac in payload phase.
- udp_txen  in  1  mac byte request; byte due on udp_txd next cycle.
- udp_txd  out  8  payload byte.
- gnt  out  2  one-hot current grant; 2'b00 when idle.
- so  out  3  state code, debug.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = requester 0.
- States, encoded in so: IDLE=0, ARB=1, WAIT=2, SEND=3, DONE=4, REJ=5.
- IDLE: go to ARB when req0|req1.
- ARB, 1 cycle:
  - Grant order: pointer first, then the other requester.
  - Latch length into udp_tx_len; set gnt.
  - If length < MIN_LEN, go to REJ. Otherwise go to WAIT.
- WAIT:
  - Assert fs_udp_tx once flag_udp_tx_prep=1; hold it high until fd_udp_tx.
  - Enter SEND on flag_udp_tx_req=1.
- SEND:
  - rd_en[gnt] = udp_txen, combinational.
  - udp_txd = registered mux of rxd[gnt], so data arrives exactly 1 cycle after udp_txen.
  - Count strobes. Strobes beyond udp_tx_len are not forwarded and do not touch the FIFO; udp_txd=0.
  - On fd_udp_tx, deassert fs_udp_tx and go to DONE.
- fd_udp_tx arriving while in WAIT: treat as completion and go to DONE, covering mac finishing before the payload flag is seen.
- DONE, 1 cycle: done[gnt]=1, gnt cleared, pointer toggled to the other requester, return to IDLE.
- REJ, 1 cycle: done[gnt]=1 and err[gnt]=1, pointer toggled, return to IDLE. fs_udp_tx never asserted.
- Simultaneous req0 and req1 in IDLE: the pointer decides; back-to-back traffic alternates 0,1,0,1.
- Request dropped mid-packet: ignored; the packet completes.
- Reset mid-packet: everything returns to reset values immediately. The FIFOs are reset by the parent.
- Byte counter: LEN_W bits; no wrap, since forwarding is capped at udp_tx_len.

Optional Feature:
- UDP_TX_TO_EN defined:
  - A 20-bit counter runs in WAIT and SEND and clears on every udp_txen.
  - On reaching TO_CYC: drop fs_udp_tx, pulse done[gnt] and err[gnt], toggle the pointer, return to IDLE.
- Not defined: no counter, err is driven only by REJ, and WAIT/SEND last until fd_udp_tx.

Decomposition:
- Shared package udp_tx_pkg:
  - State localparams IDLE..REJ.
  - LEN_W and MIN_LEN defaults.
  - Requester index constants REQ_ADC=0 and REQ_CMD=1.
- One natural sub-module: rr_arb2, the 2-way round-robin grant plus pointer. Everything else stays in udp_tx_arb.

Test Plan:
- Single packet: req0, len0=12'd8, mac model with prep=1 and 8 txen strobes.
  - Expect 8 rd_en0 pulses; udp_txd matches the FIFO bytes with 1-cycle lag.
  - Expect done0 one cycle after fd_udp_tx, err0=0.
- Contention: req0 and req1 both raised in the same cycle after reset.
  - Expect gnt=01 first, then 10; the next pair of requests again starts with 01.
- Zero length: len1=0 with req1.
  - Expect done1=err1=1 two cycles after the request, fs_udp_tx stays 0, rd_en1 never asserted.
- Over-strobe: len0=4, mac issues 6 txen.
  - Expect exactly 4 rd_en0 pulses and udp_txd=8'h00 for the last 2 bytes.
- Async reset asserted mid-SEND (byte 3 of 8): outputs go to 0 immediately; after release, so=0 and gnt=00.
- UDP_TX_TO_EN with TO_CYC=100 and mac never asserting fd_udp_tx.
  - Expect done0=err0=1 at cycle 100 after the last txen, and fs_udp_tx low.
